// File: rtl/fetch_controller_if.sv
// Fetch controller bus: PC/branch/memory handshake between the IF stage and its neighbours.
// The master modport is the fetch controller itself; the slave modport is the surrounding pipeline.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface fetch_controller_if #(
  parameter int WORD_WIDTH = `WORD_WIDTH
);
  logic [WORD_WIDTH-1:0] pc;
  logic                  hazard;
  logic                  branch_taken;
  logic [WORD_WIDTH-1:0] branch_addr;
  logic                  mem_ready;
  logic [WORD_WIDTH-1:0] pc_next;
  logic                  pc_freeze;
  logic                  if_flush;
  logic                  imem_req;
  logic                  timeout_err;
  logic [31:0]           stall_cycles;

  modport master (
    input  pc, hazard, branch_taken, branch_addr, mem_ready,
    output pc_next, pc_freeze, if_flush, imem_req, timeout_err, stall_cycles
  );

  modport slave (
    output pc, hazard, branch_taken, branch_addr, mem_ready,
    input  pc_next, pc_freeze, if_flush, imem_req, timeout_err, stall_cycles
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch controller: next-PC selection, stall/flush generation and memory-wait timeout.
// Optional frozen-cycle counter enabled by defining FETCH_PERF_COUNT_EN.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module fetch_controller #(
  parameter int WORD_WIDTH = `WORD_WIDTH,
  parameter int PC_STEP    = 4,
  parameter int TIMEOUT    = 16
) (
  input logic                clk,
  input logic                rst,
  fetch_controller_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {BOOT, FETCH, WAIT} state_t;

  state_t                state_q, state_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [WORD_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                  timeout_q, timeout_d;

  logic [WORD_WIDTH-1:0] pc_next;
  logic                  pc_freeze;
  logic                  if_flush;
  logic                  imem_req;
  logic [WORD_WIDTH-1:0] pc_seq;

  assign pc_seq = bus.pc + WORD_WIDTH'(PC_STEP);

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
    pc_next      = bus.pc;
    pc_freeze    = 1'b1;
    if_flush     = 1'b0;
    imem_req     = 1'b0;
    case (state_q)
      BOOT: begin
        if_flush = 1'b1;
        state_d  = FETCH;
      end
      FETCH: begin
        imem_req   = 1'b1;
        wait_cnt_d = '0;
        if (bus.branch_taken && bus.mem_ready) begin
          pc_next   = bus.branch_addr;
          pc_freeze = 1'b0;
          if_flush  = 1'b1;
        end else if (bus.branch_taken) begin
          pend_addr_d  = bus.branch_addr;
          pend_valid_d = 1'b1;
          wait_cnt_d   = CW'(1);
          state_d      = WAIT;
        end else if (!bus.mem_ready) begin
          wait_cnt_d = CW'(1);
          state_d    = WAIT;
        end else if (!bus.hazard) begin
          pc_next   = pc_seq;
          pc_freeze = 1'b0;
        end
      end
      WAIT: begin
        imem_req = 1'b1;
        if (!bus.mem_ready) begin
          // Latest branch resolved during the wait overrides an older pending target.
          if (bus.branch_taken) begin
            pend_addr_d  = bus.branch_addr;
            pend_valid_d = 1'b1;
          end
          if (wait_cnt_q < CW'(TIMEOUT)) wait_cnt_d = wait_cnt_q + CW'(1);
          if (wait_cnt_d == CW'(TIMEOUT)) timeout_d = 1'b1;
        end else begin
          wait_cnt_d   = '0;
          pend_valid_d = 1'b0;
          state_d      = FETCH;
          if (bus.branch_taken) begin
            pc_next   = bus.branch_addr;
            pc_freeze = 1'b0;
            if_flush  = 1'b1;
          end else if (pend_valid_q) begin
            pc_next   = pend_addr_q;
            pc_freeze = 1'b0;
            if_flush  = 1'b1;
          end else if (!bus.hazard) begin
            pc_next   = pc_seq;
            pc_freeze = 1'b0;
          end
        end
      end
      default: state_d = BOOT;
    endcase
    if (rst) begin
      pc_next   = '0;
      pc_freeze = 1'b1;
      if_flush  = 1'b1;
      imem_req  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (state_q != BOOT && pc_freeze) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt_q;
`else
  assign bus.stall_cycles = '0;
`endif

  assign bus.pc_next     = pc_next;
  assign bus.pc_freeze   = pc_freeze;
  assign bus.if_flush    = if_flush;
  assign bus.imem_req    = imem_req;
  assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: expected outputs are queued when a step is driven
// and popped for comparison at the following falling edge.
`timescale 1ns/1ps

module tb_fetch_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  string       q_tag[$];
  logic [31:0] q_pc[$];
  logic [2:0]  q_flags[$];  // {pc_freeze, if_flush, imem_req}

  fetch_controller_if bus ();

  fetch_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, act, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic act, input logic exp);
    n_checks++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, then compare mid-cycle.
  task automatic step(input string tag, input logic r, input logic [31:0] p, input logic hz,
                      input logic br, input logic [31:0] ba, input logic mr,
                      input logic [31:0] epc, input logic efz, input logic efl, input logic erq);
    string       t;
    logic [31:0] e_pc;
    logic [2:0]  e_fl;
    @(posedge clk);
    #1;
    rst              = r;
    bus.pc           = p;
    bus.hazard       = hz;
    bus.branch_taken = br;
    bus.branch_addr  = ba;
    bus.mem_ready    = mr;
    q_tag.push_back(tag);
    q_pc.push_back(epc);
    q_flags.push_back({efz, efl, erq});
    @(negedge clk);
    t    = q_tag.pop_front();
    e_pc = q_pc.pop_front();
    e_fl = q_flags.pop_front();
    chk32({t, ".pc_next"}, bus.pc_next, e_pc);
    chk1({t, ".pc_freeze"}, bus.pc_freeze, e_fl[2]);
    chk1({t, ".if_flush"}, bus.if_flush, e_fl[1]);
    chk1({t, ".imem_req"}, bus.imem_req, e_fl[0]);
    $display("step %-14s pc=0x%08h next=0x%08h frz=%b fl=%b req=%b to=%b",
             t, p, bus.pc_next, bus.pc_freeze, bus.if_flush, bus.imem_req, bus.timeout_err);
  endtask

  initial begin
    bus.pc           = '0;
    bus.hazard       = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_addr  = '0;
    bus.mem_ready    = 1'b1;

    // Reset and boot, then sequential fetch
    step("rst0", 1, 32'h0, 0, 0, 0, 1, 32'h0, 1, 1, 0);
    step("rst1", 1, 32'h0, 0, 0, 0, 1, 32'h0, 1, 1, 0);
    chk1("rst.timeout_err", bus.timeout_err, 1'b0);
    chk32("rst.stall_cycles", bus.stall_cycles, 32'h0);
    step("boot", 0, 32'h0, 0, 0, 0, 1, 32'h0, 1, 1, 0);
    step("seq4", 0, 32'h0, 0, 0, 0, 1, 32'h4, 0, 0, 1);
    step("seq8", 0, 32'h4, 0, 0, 0, 1, 32'h8, 0, 0, 1);
    step("seq12", 0, 32'h8, 0, 0, 0, 1, 32'hC, 0, 0, 1);

    // Hazard stall
    step("haz0", 0, 32'h20, 1, 0, 0, 1, 32'h20, 1, 0, 1);
    step("haz1", 0, 32'h20, 1, 0, 0, 1, 32'h20, 1, 0, 1);
    step("haz_rel", 0, 32'h20, 0, 0, 0, 1, 32'h24, 0, 0, 1);

    // Immediate branch, hazard ignored
    step("br_now", 0, 32'h40, 1, 1, 32'h100, 1, 32'h100, 0, 1, 1);

    // Branches during a memory wait: latest wins
    step("wbr1", 0, 32'h40, 0, 1, 32'h200, 0, 32'h40, 1, 0, 1);
    step("wbr2", 0, 32'h40, 0, 1, 32'h300, 0, 32'h40, 1, 0, 1);
    step("wbr3", 0, 32'h40, 0, 0, 32'h0, 0, 32'h40, 1, 0, 1);
    step("wbr_rdy", 0, 32'h40, 0, 0, 32'h0, 1, 32'h300, 0, 1, 1);

    // PC wrap
    step("wrap", 0, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'h0, 0, 0, 1);

    // Branch arriving together with mem_ready in WAIT
    step("w2_enter", 0, 32'h50, 0, 0, 0, 0, 32'h50, 1, 0, 1);
    step("w2_br", 0, 32'h50, 0, 1, 32'h700, 1, 32'h700, 0, 1, 1);

    // Hazard when memory returns in WAIT, then normal fetch
    step("w3_enter", 0, 32'h58, 0, 0, 0, 0, 32'h58, 1, 0, 1);
    step("w3_haz", 0, 32'h58, 1, 0, 0, 1, 32'h58, 1, 0, 1);
    step("w3_fetch", 0, 32'h58, 0, 0, 0, 1, 32'h5C, 0, 0, 1);

    // Reset mid-wait discards the pending branch
    step("rw_enter", 0, 32'h60, 0, 1, 32'h500, 0, 32'h60, 1, 0, 1);
    step("rw_rst", 1, 32'h60, 0, 0, 0, 0, 32'h0, 1, 1, 0);
    step("rw_boot", 0, 32'h60, 0, 0, 0, 0, 32'h60, 1, 1, 0);
    step("rw_wait", 0, 32'h60, 0, 0, 0, 0, 32'h60, 1, 0, 1);
    step("rw_rdy", 0, 32'h60, 0, 0, 0, 1, 32'h64, 0, 0, 1);

    // Timeout after a fresh reset; 20 frozen cycles
    step("to_rst", 1, 32'h80, 0, 0, 0, 1, 32'h0, 1, 1, 0);
    step("to_boot", 0, 32'h80, 0, 0, 0, 0, 32'h80, 1, 1, 0);
    for (int i = 1; i <= 20; i++) begin
      step($sformatf("to_w%0d", i), 0, 32'h80, 0, 0, 0, 0, 32'h80, 1, 0, 1);
      if (i == 10) chk1("to.early_clear", bus.timeout_err, 1'b0);
      if (i == 20) chk1("to.raised", bus.timeout_err, 1'b1);
    end
    step("to_rdy", 0, 32'h80, 0, 0, 0, 1, 32'h84, 0, 0, 1);
`ifdef FETCH_PERF_COUNT_EN
    chk32("to.stall_cycles", bus.stall_cycles, 32'd20);
`else
    chk32("to.stall_cycles", bus.stall_cycles, 32'd0);
`endif
    step("to_after", 0, 32'h84, 0, 0, 0, 1, 32'h88, 0, 0, 1);
    chk1("to.sticky", bus.timeout_err, 1'b1);

    chk1("scoreboard.empty", (q_tag.size() == 0) ? 1'b1 : 1'b0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter WORD_WIDTH, 32, address/instruction width, equal to the global `WORD_WIDTH.
REQ-002 Parameter PC_STEP, 4, sequential PC increment in bytes.
REQ-003 Parameter TIMEOUT, 16, WAIT-state cycle count that raises timeout_err.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; it SHALL be synchronous and active-high.
REQ-006 pc  in  WORD_WIDTH  current PC register value.
REQ-007 hazard  in  1  data-hazard stall request from hazard detection.
REQ-008 branch_taken  in  1  EXE-stage branch resolved taken this cycle.
REQ-009 branch_addr  in  WORD_WIDTH  branch target, valid with branch_taken.
REQ-010 mem_ready  in  1  instruction memory has returned the word for pc.
REQ-011 pc_next  out  WORD_WIDTH  value driven to the PC register input.
REQ-012 pc_freeze  out  1  holds the PC register and IF/ID register.
REQ-013 if_flush  out  1  invalidates the IF/ID instruction.
REQ-014 imem_req  out  1  instruction fetch request.
REQ-015 timeout_err  out  1  sticky: memory wait exceeded TIMEOUT.
REQ-016 stall_cycles  out  32  frozen-cycle count (see Configuration).

Function
REQ-017 pc_next, pc_freeze, if_flush and imem_req SHALL be combinational from state, pend registers and inputs; state, pend_valid, pend_addr, wait_cnt, timeout_err and stall_cycles SHALL be registered.
REQ-018 States: BOOT, FETCH, WAIT; BOOT SHALL last exactly one cycle after rst deasserts (imem_req=0, pc_freeze=1, if_flush=1) and then go to FETCH.
REQ-019 FETCH and WAIT SHALL drive imem_req=1.
REQ-020 FETCH priority 1: branch_taken & mem_ready -> pc_next=branch_addr, pc_freeze=0, if_flush=1, stay FETCH (hazard ignored).
REQ-021 FETCH priority 2: branch_taken & !mem_ready -> pend_addr<=branch_addr, pend_valid<=1, pc_freeze=1, go WAIT.
REQ-022 FETCH priority 3: !mem_ready -> pc_freeze=1, wait_cnt<=1, go WAIT.
REQ-023 FETCH priority 4: hazard -> pc_freeze=1, pc_next=pc, if_flush=0.
REQ-024 FETCH otherwise: pc_next=pc+PC_STEP (modulo 2^WORD_WIDTH, wrap to 0), pc_freeze=0, if_flush=0.
REQ-025 WAIT: pc_freeze=1 while !mem_ready; branch_taken SHALL overwrite pend_addr (latest branch wins) and set pend_valid.
REQ-026 WAIT & mem_ready: if branch_taken -> pc_next=branch_addr; else if pend_valid -> pc_next=pend_addr; either case pc_freeze=0, if_flush=1, pend_valid<=0, go FETCH.
REQ-027 WAIT & mem_ready, no branch/pending: hazard -> pc_freeze=1, go FETCH; else pc_next=pc+PC_STEP, pc_freeze=0, go FETCH.
REQ-028 wait_cnt SHALL increment each WAIT cycle, saturating at TIMEOUT; reaching TIMEOUT SHALL set timeout_err, which stays set until rst; state remains WAIT.
REQ-029 When pc_freeze=1, pc_next SHALL equal pc unless REQ-020/026 apply.

Reset
REQ-030 While rst=1: state<=BOOT, pend_valid<=0, pend_addr<=0, wait_cnt<=0, timeout_err<=0, stall_cycles<=0; outputs pc_next=0, pc_freeze=1, if_flush=1, imem_req=0.
REQ-031 rst asserted mid-WAIT SHALL discard any pending branch.

Configuration
REQ-032 Macro FETCH_PERF_COUNT_EN: defined -> stall_cycles increments (wrapping) every cycle pc_freeze=1 outside BOOT and reset; undefined -> stall_cycles tied to 0 and no counter register exists.

Verification
REQ-033 Reset release, pc=0, mem_ready=1 -> one BOOT cycle (freeze=1, req=0), then pc_next=4, 8, 12 on successive cycles.
REQ-034 pc=0x20, hazard=1 for 2 cycles -> pc_freeze=1, pc_next=0x20 both cycles; then pc_next=0x24.
REQ-035 pc=0x40, branch_taken=1, branch_addr=0x100, mem_ready=1 -> pc_next=0x100, if_flush=1, freeze=0 same cycle.
REQ-036 pc=0x40, mem_ready=0 3 cycles, branch 0x200 in cycle 1 then 0x300 in cycle 2 -> freeze held; on mem_ready pc_next=0x300, if_flush=1.
REQ-037 mem_ready=0 for 20 cycles (TIMEOUT=16) -> timeout_err=1 after 16 WAIT cycles, stays 1 after mem_ready; with FETCH_PERF_COUNT_EN, stall_cycles=20.
REQ-038 pc=0xFFFFFFFC, mem_ready=1, no hazard -> pc_next=0x00000000.
